// File: rtl/nf_seven_seg_pkg.sv
// nf_seven_seg_pkg: segment pattern type and hex glyph decoder shared by the seven-segment drivers
package nf_seven_seg_pkg;
    typedef logic [7:0] seg_t;
    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        return GLYPHS[h];
    endfunction
endpackage

// File: rtl/nf_seven_seg_scan.sv
// nf_seven_seg_scan: slot prescaler, digit index, anti-ghost blank window and frame wrap detect
module nf_seven_seg_scan #(
    parameter int HN = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC = 500,
    localparam int IW = HN > 1 ? $clog2(HN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic [IW-1:0] idx,
    output logic          blank,
    output logic          wrap
);
    localparam int PW = $clog2(REFRESH_DIV);
    logic [PW-1:0] presc;
    logic          tc;
    logic          last;
    assign tc = presc == PW'(REFRESH_DIV - 1);
    assign last = idx == IW'(HN - 1);
    assign blank = presc < PW'(BLANK_CYC);
    assign wrap = tc && last;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx <= '0;
        end else begin
            presc <= tc ? '0 : presc + 1'b1;
            if (tc) idx <= last ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/nf_seven_seg_dynamic.sv
// nf_seven_seg_dynamic: multiplexed seven-segment driver with tear-free double buffer and frame strobe
// NF_SEVEN_SEG_LZB_EN: blank leading-zero digits (digit 0 always shown)
module nf_seven_seg_dynamic
    import nf_seven_seg_pkg::*;
#(
    parameter int HN = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4*HN-1:0] hex,
    input  logic [HN-1:0]   dp,
    input  logic            hex_we,
    input  logic            cc_ca,
    output logic [7:0]      seven_seg,
    output logic [HN-1:0]   dig_sel,
    output logic            frame_end
);
    localparam int IW = HN > 1 ? $clog2(HN) : 1;
    logic [IW-1:0]   idx;
    logic            blank;
    logic            wrap;
    logic [4*HN-1:0] pend_hex;
    logic [4*HN-1:0] act_hex;
    logic [HN-1:0]   pend_dp;
    logic [HN-1:0]   act_dp;
    logic            pend;
    logic [HN-1:0]   show;
    logic [3:0]      nib;
    seg_t            seg_d;
    seg_t            seg_q;
    logic [HN-1:0]   sel_d;
    logic [HN-1:0]   sel_q;
    logic            fe_q;

    nf_seven_seg_scan #(.HN(HN), .REFRESH_DIV(REFRESH_DIV), .BLANK_CYC(BLANK_CYC)) u_scan (
        .clk(clk),
        .reset(reset),
        .idx(idx),
        .blank(blank),
        .wrap(wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_hex <= '0;
            pend_dp <= '0;
            pend <= 1'b0;
            act_hex <= '0;
            act_dp <= '0;
        end else if (wrap) begin
            if (hex_we) begin
                act_hex <= hex;
                act_dp <= dp;
            end else if (pend) begin
                act_hex <= pend_hex;
                act_dp <= pend_dp;
            end
            pend <= 1'b0;
        end else if (hex_we) begin
            pend_hex <= hex;
            pend_dp <= dp;
            pend <= 1'b1;
        end
    end

`ifdef NF_SEVEN_SEG_LZB_EN
    always_comb begin
        logic acc;
        acc = 1'b0;
        show = '0;
        for (int i = HN - 1; i >= 0; i--) begin
            acc = acc | (|act_hex[4*i +: 4]);
            show[i] = acc || i == 0;
        end
    end
`else
    assign show = '1;
`endif

    assign nib = act_hex[{idx, 2'b00} +: 4];
    assign seg_d = {act_dp[idx], show[idx] ? hex2seg(nib) : 7'h00};
    assign sel_d = blank ? '0 : HN'(1) << idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= '0;
            sel_q <= '0;
            fe_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            sel_q <= sel_d;
            fe_q <= wrap;
        end
    end

    assign seven_seg = seg_q ^ {8{cc_ca}};
    assign dig_sel = sel_q ^ {HN{cc_ca}};
    assign frame_end = fe_q;
endmodule

// File: tb/tb_nf_seven_seg_dynamic.sv
// tb_nf_seven_seg_dynamic: randomized scoreboard bench, HN=4, REFRESH_DIV=10, BLANK_CYC=2
module tb_nf_seven_seg_dynamic;
    localparam int HN = 4;
    localparam int SLOT = 10;
    localparam int BLK = 2;
    localparam int FRAME = HN * SLOT;
`ifdef NF_SEVEN_SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] hex = '0;
    logic [3:0]  dp = '0;
    logic        hex_we = 1'b0;
    logic        cc_ca = 1'b0;
    logic [7:0]  seven_seg;
    logic [3:0]  dig_sel;
    logic        frame_end;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          k = 0;
    int          j = 0;
    bit          prev_blank = 1'b1;
    int          cc_mode = 0;
    logic        next_cc = 1'b0;
    logic [15:0] last_hex = '0;
    logic [3:0]  last_dp = '0;

    nf_seven_seg_dynamic #(.HN(HN), .REFRESH_DIV(SLOT), .BLANK_CYC(BLK)) dut (
        .clk(clk),
        .reset(reset),
        .hex(hex),
        .dp(dp),
        .hex_we(hex_we),
        .cc_ca(cc_ca),
        .seven_seg(seven_seg),
        .dig_sel(dig_sel),
        .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, j);
        end
    endtask

    function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] dpv, input int d, input logic cc);
        logic [15:0] sh;
        logic        off;
        sh = v >> (4 * d);
        off = LZB && d > 0 && sh == 16'h0;
        return {dpv[d], off ? 7'h00 : GLYPH[sh[3:0]]} ^ {8{cc}};
    endfunction

    // Each frame shows whatever was last written before that frame began.
    task automatic run(input int ncyc, input int wpct, input int fofs, input logic [15:0] fhex, input logic [3:0] fdp);
        for (int n = 0; n < ncyc; n++) begin
            if (k % FRAME == 0) begin
                next_cc = cc_mode == 2 ? 1'($urandom) : 1'(cc_mode);
                for (int d = 0; d < HN; d++)
                    q.push_back('{seg: exp_seg(last_hex, last_dp, d, next_cc), sel: (4'b1 << d) ^ {4{next_cc}}});
            end
            if (k % FRAME == 1) cc_ca = next_cc;
            hex_we = 1'b0;
            if (k % FRAME == fofs) begin
                hex = fhex;
                dp = fdp;
                hex_we = 1'b1;
            end else if (int'($urandom_range(99)) < wpct) begin
                hex = 16'($urandom);
                dp = 4'($urandom);
                hex_we = 1'b1;
            end
            if (hex_we) begin
                last_hex = hex;
                last_dp = dp;
            end
            @(posedge clk);
            #1;
            k++;
        end
        hex_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_seg", 32'(seven_seg), 32'({8{cc_ca}}));
        chk("rst_sel", 32'(dig_sel), 32'({4{cc_ca}}));
        chk("rst_fe", 32'(frame_end), 32'(0));
        q.delete();
        last_hex = '0;
        last_dp = '0;
        hex_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0;
    endtask

    // Reset lands at prescaler 5 of digit 2 with a write still pending.
    task automatic mid_reset();
        run(2 * SLOT + 4, 0, -1, '0, '0);
        hex = 16'h9999;
        dp = 4'hF;
        hex_we = 1'b1;
        @(posedge clk);
        #1;
        k++;
        hex_we = 1'b0;
        do_reset();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            j = 0;
            prev_blank = 1'b1;
        end else begin
            logic [3:0] es;
            es = (j == 0 || (j - 1) % SLOT < BLK) ? 4'b0 : 4'b1 << (((j - 1) / SLOT) % HN);
            chk("dig_sel", 32'(dig_sel), 32'(es ^ {4{cc_ca}}));
            chk("frame_end", 32'(frame_end), 32'(j > 0 && j % FRAME == 0));
            if (dig_sel !== {4{cc_ca}}) begin
                if (prev_blank) begin
                    if (q.size() == 0) begin
                        chk("slot_queue", 32'(0), 32'(1));
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("slot_seg", 32'(seven_seg), 32'(e.seg));
                        chk("slot_sel", 32'(dig_sel), 32'(e.sel));
                    end
                end
                prev_blank = 1'b0;
            end else begin
                prev_blank = 1'b1;
            end
            j++;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        run(FRAME, 0, 10, 16'h1234, 4'b0001);
        run(FRAME, 0, 15, 16'hABCD, 4'b0000);
        run(FRAME, 0, FRAME - 1, 16'h0050, 4'b0000);
        run(FRAME, 0, FRAME - 1, 16'h0000, 4'b0000);
        run(FRAME, 0, 5, 16'h1234, 4'b0001);
        cc_mode = 1;
        run(2 * FRAME, 0, 20, 16'h00A0, 4'b1000);
        mid_reset();
        cc_mode = 0;
        run(2 * FRAME, 0, -1, '0, '0);
        cc_mode = 2;
        run(20 * FRAME, 10, FRAME - 1, 16'hF00F, 4'b0110);
        cc_mode = 0;
        run(FRAME, 0, -1, '0, '0);
        mid_reset();
        run(2 * FRAME, 20, -1, '0, '0);
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
